// File: rtl/rf_wport_arbiter_pkg.sv
// rf_wport_arbiter_pkg
//   Shared types and widths for the register-file write-port arbiter.
//   REG_ADDR_W / DATA_W : regfile address and data widths
//   arb_state_t         : arbiter FSM encoding (NORMAL, FORCE)
//   wb_req_t            : one write-back request {we, addr, data}
package rf_wport_arbiter_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;

    typedef enum logic [0:0] {
        NORMAL = 1'b0,
        FORCE  = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic                  we;
        logic [REG_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]     data;
    } wb_req_t;

endpackage

// File: rtl/rf_wbuf.sv
// rf_wbuf
//   Circular buffer for multi-cycle results waiting for the regfile write port.
//   Each entry carries its own valid bit so a newer pipeline write can cancel
//   it in place (kill-by-address) without disturbing FIFO order.
// Ports:
//   clk, rstn              clock, async active-low reset
//   push_en/addr/data      write a new entry at the tail
//   pop                    retire the head entry (valid or not)
//   kill_en/kill_addr      clear valid on every live entry targeting kill_addr
//   q_addr / q_hit         lookup: some valid entry targets q_addr (combinational)
//   full, empty            occupancy, from the pointers only
//   head_valid/addr/data   current head entry
module rf_wbuf
    import rf_wport_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  push_en,
    input  logic [REG_ADDR_W-1:0] push_addr,
    input  logic [DATA_W-1:0]     push_data,
    input  logic                  pop,
    input  logic                  kill_en,
    input  logic [REG_ADDR_W-1:0] kill_addr,
    input  logic [REG_ADDR_W-1:0] q_addr,
    output logic                  q_hit,
    output logic                  full,
    output logic                  empty,
    output logic                  head_valid,
    output logic [REG_ADDR_W-1:0] head_addr,
    output logic [DATA_W-1:0]     head_data
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] PTR_ONE = (PW + 1)'(1);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PW:0]           wr_ptr;
    logic [PW:0]           rd_ptr;
    logic [PW-1:0]         wr_idx;
    logic [PW-1:0]         rd_idx;
    logic [DEPTH-1:0]      valid;
    logic [REG_ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0]     data_mem [DEPTH];

    assign wr_idx     = wr_ptr[PW-1:0];
    assign rd_idx     = rd_ptr[PW-1:0];
    assign empty      = (wr_ptr == rd_ptr);
    assign full       = (wr_ptr[PW] != rd_ptr[PW]) && (wr_idx == rd_idx);
    assign head_valid = !empty && valid[rd_idx];
    assign head_addr  = addr_mem[rd_idx];
    assign head_data  = data_mem[rd_idx];

    // Statement order matters: a push lands after the kill loop, so an entry
    // written this cycle with the killed address survives (it is younger).
    // Popped slots are cleared so only live entries ever hold valid=1.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (kill_en && valid[i] && (addr_mem[i] == kill_addr)) begin
                    valid[i] <= 1'b0;
                end
            end
            if (pop) begin
                valid[rd_idx] <= 1'b0;
                rd_ptr        <= rd_ptr + PTR_ONE;
            end
            if (push_en) begin
                valid[wr_idx] <= 1'b1;
                wr_ptr        <= wr_ptr + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) begin
            addr_mem[wr_idx] <= push_addr;
            data_mem[wr_idx] <= push_data;
        end
    end

    always_comb begin
        q_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && (addr_mem[i] == q_addr)) begin
                q_hit = 1'b1;
            end
        end
        if (q_addr == '0) begin
            q_hit = 1'b0;
        end
    end

endmodule

// File: rtl/rf_wport_arbiter.sv
// rf_wport_arbiter
//   Shares the single regfile write port between the in-order pipeline
//   write-back and buffered multi-cycle results. The pipeline wins by default;
//   a starvation counter forces one buffered write by stalling the pipeline.
// Ports:
//   clk, rstn                    clock, async active-low reset
//   pipe_we/addr/data            pipeline write-back request
//   mc_valid/addr/data, mc_ready multi-cycle result handshake
//   q_addr, q_pending            hazard-unit lookup of buffered writes
//   pipe_stall                   pipeline must hold its write-back inputs
//   rf_we/addr/data              registered regfile write
module rf_wport_arbiter
    import rf_wport_arbiter_pkg::*;
#(
    parameter int DEPTH    = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  pipe_we,
    input  logic [REG_ADDR_W-1:0] pipe_addr,
    input  logic [DATA_W-1:0]     pipe_data,
    input  logic                  mc_valid,
    input  logic [REG_ADDR_W-1:0] mc_addr,
    input  logic [DATA_W-1:0]     mc_data,
    output logic                  mc_ready,
    input  logic [REG_ADDR_W-1:0] q_addr,
    output logic                  q_pending,
    output logic                  pipe_stall,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_addr,
    output logic [DATA_W-1:0]     rf_data
);

    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] WAIT_LIMIT = CW'(MAX_WAIT);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    arb_state_t            state;
    arb_state_t            state_nxt;
    logic [CW-1:0]         wait_cnt;
    logic [CW-1:0]         wait_nxt;
    logic                  pe;
    logic                  full;
    logic                  empty;
    logic                  head_valid;
    logic [REG_ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0]     head_data;
    logic                  grant_pipe;
    logic                  grant_head;
    logic                  pop;
    logic                  push_en;
    wb_req_t               win;

    assign pe         = pipe_we && (pipe_addr != '0);
    assign mc_ready   = !full;
    // Writes to r0 are handshaken but never stored.
    assign push_en    = mc_valid && !full && (mc_addr != '0);
    assign pipe_stall = (state == FORCE);

    rf_wbuf #(
        .DEPTH(DEPTH)
    ) u_wbuf (
        .clk        (clk),
        .rstn       (rstn),
        .push_en    (push_en),
        .push_addr  (mc_addr),
        .push_data  (mc_data),
        .pop        (pop),
        .kill_en    (grant_pipe),
        .kill_addr  (pipe_addr),
        .q_addr     (q_addr),
        .q_hit      (q_pending),
        .full       (full),
        .empty      (empty),
        .head_valid (head_valid),
        .head_addr  (head_addr),
        .head_data  (head_data)
    );

    // An invalid (killed) head is popped whenever the port is not needed for
    // it, including alongside a pipeline write, since it writes nothing.
    // In FORCE the head is popped whether or not it survived the entry edge.
    always_comb begin
        grant_pipe = 1'b0;
        grant_head = 1'b0;
        pop        = 1'b0;
        wait_nxt   = '0;
        state_nxt  = NORMAL;
        if (state == FORCE) begin
            grant_head = head_valid;
            pop        = !empty;
        end else begin
            if (pe) begin
                grant_pipe = 1'b1;
                if (head_valid) begin
                    wait_nxt = wait_cnt + CNT_ONE;
                end else begin
                    pop = !empty;
                end
            end else begin
                grant_head = head_valid;
                pop        = !empty;
            end
            if (wait_nxt == WAIT_LIMIT) begin
                state_nxt = FORCE;
            end
        end
    end

    always_comb begin
        win = '0;
        if (grant_pipe) begin
            win = '{we: 1'b1, addr: pipe_addr, data: pipe_data};
        end else if (grant_head) begin
            win = '{we: 1'b1, addr: head_addr, data: head_data};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= NORMAL;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
        end
    end

    // Address/data hold their last value on idle cycles; only rf_we qualifies them.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rf_we   <= 1'b0;
            rf_addr <= '0;
            rf_data <= '0;
        end else begin
            rf_we <= win.we;
            if (win.we) begin
                rf_addr <= win.addr;
                rf_data <= win.data;
            end
        end
    end

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// tb_rf_wport_arbiter
//   Directed-vector bench for rf_wport_arbiter (DEPTH=2, MAX_WAIT=4).
//   Each vector row holds the inputs for one cycle, the expected combinational
//   outputs during that cycle, and the expected regfile write after its edge.
module tb_rf_wport_arbiter;

    logic        clk;
    logic        rstn;
    logic        pipe_we;
    logic [4:0]  pipe_addr;
    logic [31:0] pipe_data;
    logic        mc_valid;
    logic [4:0]  mc_addr;
    logic [31:0] mc_data;
    logic        mc_ready;
    logic [4:0]  q_addr;
    logic        q_pending;
    logic        pipe_stall;
    logic        rf_we;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;

    int n_compared;
    int n_mismatched;

    typedef struct {
        logic        pwe;
        logic [4:0]  paddr;
        logic [31:0] pdata;
        logic        mv;
        logic [4:0]  maddr;
        logic [31:0] mdata;
        logic [4:0]  qa;
        logic        stall;
        logic        ready;
        logic        qp;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } vec_t;

    vec_t vecs[$];

    rf_wport_arbiter #(
        .DEPTH    (2),
        .MAX_WAIT (4)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .pipe_we    (pipe_we),
        .pipe_addr  (pipe_addr),
        .pipe_data  (pipe_data),
        .mc_valid   (mc_valid),
        .mc_addr    (mc_addr),
        .mc_data    (mc_data),
        .mc_ready   (mc_ready),
        .q_addr     (q_addr),
        .q_pending  (q_pending),
        .pipe_stall (pipe_stall),
        .rf_we      (rf_we),
        .rf_addr    (rf_addr),
        .rf_data    (rf_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic pwe, input logic [4:0] paddr, input logic [31:0] pdata,
                                 input logic mv, input logic [4:0] maddr, input logic [31:0] mdata,
                                 input logic [4:0] qa);
        pipe_we   = pwe;
        pipe_addr = paddr;
        pipe_data = pdata;
        mc_valid  = mv;
        mc_addr   = maddr;
        mc_data   = mdata;
        q_addr    = qa;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic addVec(input logic pwe, input logic [4:0] paddr, input logic [31:0] pdata,
                          input logic mv, input logic [4:0] maddr, input logic [31:0] mdata,
                          input logic [4:0] qa, input logic stall, input logic ready, input logic qp,
                          input logic we, input logic [4:0] waddr, input logic [31:0] wdata);
        vec_t v;
        v.pwe = pwe;     v.paddr = paddr; v.pdata = pdata;
        v.mv = mv;       v.maddr = maddr; v.mdata = mdata;
        v.qa = qa;       v.stall = stall; v.ready = ready; v.qp = qp;
        v.we = we;       v.waddr = waddr; v.wdata = wdata;
        vecs.push_back(v);
    endtask

    task automatic checkIdleReset(input string tag);
        checkOutput({tag, "_rf_we"},   64'(rf_we),      64'(0));
        checkOutput({tag, "_rf_addr"}, 64'(rf_addr),    64'(0));
        checkOutput({tag, "_rf_data"}, 64'(rf_data),    64'(0));
        checkOutput({tag, "_stall"},   64'(pipe_stall), 64'(0));
        checkOutput({tag, "_ready"},   64'(mc_ready),   64'(1));
        checkOutput({tag, "_qpend"},   64'(q_pending),  64'(0));
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        rstn = 1'b0;
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0);
        checkIdleReset("reset");

        // Single pipeline write: visible one cycle after the grant.
        addVec(1'b1, 5'd5, 32'h11, 1'b0, 5'd0, 32'h0, 5'd0,  1'b0, 1'b1, 1'b0,  1'b1, 5'd5, 32'h11);
        addVec(1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0, 5'd0,  1'b0, 1'b1, 1'b0,  1'b0, 5'd0, 32'h0);
        // Multi-cycle push with idle pipe: write two cycles after the push.
        addVec(1'b0, 5'd0, 32'h0,  1'b1, 5'd7, 32'hAA, 5'd7, 1'b0, 1'b1, 1'b0,  1'b0, 5'd0, 32'h0);
        addVec(1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  5'd7, 1'b0, 1'b1, 1'b1,  1'b1, 5'd7, 32'hAA);
        addVec(1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  5'd7, 1'b0, 1'b1, 1'b0,  1'b0, 5'd0, 32'h0);
        // Starvation: four denials, one stall cycle, then the held pipe write.
        addVec(1'b1, 5'd3, 32'h30, 1'b1, 5'd9, 32'h99, 5'd9, 1'b0, 1'b1, 1'b0,  1'b1, 5'd3, 32'h30);
        addVec(1'b1, 5'd3, 32'h31, 1'b0, 5'd0, 32'h0,  5'd9, 1'b0, 1'b1, 1'b1,  1'b1, 5'd3, 32'h31);
        addVec(1'b1, 5'd3, 32'h32, 1'b0, 5'd0, 32'h0,  5'd9, 1'b0, 1'b1, 1'b1,  1'b1, 5'd3, 32'h32);
        addVec(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'h0,  5'd9, 1'b0, 1'b1, 1'b1,  1'b1, 5'd3, 32'h33);
        addVec(1'b1, 5'd3, 32'h34, 1'b0, 5'd0, 32'h0,  5'd9, 1'b0, 1'b1, 1'b1,  1'b1, 5'd3, 32'h34);
        addVec(1'b1, 5'd3, 32'h35, 1'b0, 5'd0, 32'h0,  5'd9, 1'b1, 1'b1, 1'b1,  1'b1, 5'd9, 32'h99);
        addVec(1'b1, 5'd3, 32'h35, 1'b0, 5'd0, 32'h0,  5'd9, 1'b0, 1'b1, 1'b0,  1'b1, 5'd3, 32'h35);
        addVec(1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  5'd9, 1'b0, 1'b1, 1'b0,  1'b0, 5'd0, 32'h0);
        // Kill: newer pipeline write to r4 cancels the buffered r4 result.
        addVec(1'b0, 5'd0, 32'h0,  1'b1, 5'd4, 32'h1,  5'd4, 1'b0, 1'b1, 1'b0,  1'b0, 5'd0, 32'h0);
        addVec(1'b1, 5'd4, 32'h2,  1'b0, 5'd0, 32'h0,  5'd4, 1'b0, 1'b1, 1'b1,  1'b1, 5'd4, 32'h2);
        addVec(1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  5'd4, 1'b0, 1'b1, 1'b0,  1'b0, 5'd0, 32'h0);
        addVec(1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  5'd4, 1'b0, 1'b1, 1'b0,  1'b0, 5'd0, 32'h0);
        // Fill both entries with the pipe busy; third result waits for a pop.
        addVec(1'b1, 5'd3, 32'h40, 1'b1, 5'd10, 32'hA0, 5'd12, 1'b0, 1'b1, 1'b0, 1'b1, 5'd3,  32'h40);
        addVec(1'b1, 5'd3, 32'h41, 1'b1, 5'd11, 32'hB0, 5'd12, 1'b0, 1'b1, 1'b0, 1'b1, 5'd3,  32'h41);
        addVec(1'b1, 5'd3, 32'h42, 1'b1, 5'd12, 32'hC0, 5'd12, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3,  32'h42);
        addVec(1'b1, 5'd3, 32'h43, 1'b1, 5'd12, 32'hC0, 5'd12, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3,  32'h43);
        addVec(1'b1, 5'd3, 32'h44, 1'b1, 5'd12, 32'hC0, 5'd12, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3,  32'h44);
        addVec(1'b1, 5'd3, 32'h45, 1'b1, 5'd12, 32'hC0, 5'd12, 1'b1, 1'b0, 1'b0, 1'b1, 5'd10, 32'hA0);
        addVec(1'b1, 5'd3, 32'h45, 1'b1, 5'd12, 32'hC0, 5'd12, 1'b0, 1'b1, 1'b0, 1'b1, 5'd3,  32'h45);
        addVec(1'b0, 5'd0, 32'h0,  1'b0, 5'd0,  32'h0,  5'd12, 1'b0, 1'b0, 1'b1, 1'b1, 5'd11, 32'hB0);
        addVec(1'b0, 5'd0, 32'h0,  1'b0, 5'd0,  32'h0,  5'd12, 1'b0, 1'b1, 1'b1, 1'b1, 5'd12, 32'hC0);
        addVec(1'b0, 5'd0, 32'h0,  1'b0, 5'd0,  32'h0,  5'd12, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  32'h0);
        // Writes to r0 from either source are dropped.
        addVec(1'b1, 5'd0, 32'h55, 1'b1, 5'd0, 32'h66, 5'd0, 1'b0, 1'b1, 1'b0,  1'b0, 5'd0, 32'h0);
        addVec(1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  5'd0, 1'b0, 1'b1, 1'b0,  1'b0, 5'd0, 32'h0);
        // Drive the buffer full and into FORCE ahead of the reset test.
        addVec(1'b1, 5'd3, 32'h50, 1'b1, 5'd10, 32'hD0, 5'd10, 1'b0, 1'b1, 1'b0, 1'b1, 5'd3, 32'h50);
        addVec(1'b1, 5'd3, 32'h51, 1'b1, 5'd11, 32'hD1, 5'd10, 1'b0, 1'b1, 1'b1, 1'b1, 5'd3, 32'h51);
        addVec(1'b1, 5'd3, 32'h52, 1'b1, 5'd12, 32'hD2, 5'd10, 1'b0, 1'b0, 1'b1, 1'b1, 5'd3, 32'h52);
        addVec(1'b1, 5'd3, 32'h53, 1'b1, 5'd12, 32'hD2, 5'd10, 1'b0, 1'b0, 1'b1, 1'b1, 5'd3, 32'h53);
        addVec(1'b1, 5'd3, 32'h54, 1'b1, 5'd12, 32'hD2, 5'd10, 1'b0, 1'b0, 1'b1, 1'b1, 5'd3, 32'h54);

        tick();
        #5;
        rstn = 1'b1;
        tick();

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].pwe, vecs[i].paddr, vecs[i].pdata,
                          vecs[i].mv, vecs[i].maddr, vecs[i].mdata, vecs[i].qa);
            checkOutput($sformatf("v%0d_stall", i), 64'(pipe_stall), 64'(vecs[i].stall));
            checkOutput($sformatf("v%0d_ready", i), 64'(mc_ready),   64'(vecs[i].ready));
            checkOutput($sformatf("v%0d_qpend", i), 64'(q_pending),  64'(vecs[i].qp));
            tick();
            checkOutput($sformatf("v%0d_rf_we", i), 64'(rf_we), 64'(vecs[i].we));
            if (vecs[i].we) begin
                checkOutput($sformatf("v%0d_rf_addr", i), 64'(rf_addr), 64'(vecs[i].waddr));
                checkOutput($sformatf("v%0d_rf_data", i), 64'(rf_data), 64'(vecs[i].wdata));
            end
        end

        // In FORCE with a full buffer: confirm, then reset mid-cycle.
        applyStimulus(1'b1, 5'd3, 32'h55, 1'b1, 5'd12, 32'hD2, 5'd10);
        checkOutput("pre_rst_stall", 64'(pipe_stall), 64'(1));
        checkOutput("pre_rst_ready", 64'(mc_ready),   64'(0));
        checkOutput("pre_rst_qpend", 64'(q_pending),  64'(1));
        checkOutput("pre_rst_rf_we", 64'(rf_we),      64'(1));
        rstn = 1'b0;
        #1;
        checkIdleReset("async_rst");

        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd10);
        tick();
        rstn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput($sformatf("post_rst%0d_rf_we", k), 64'(rf_we),      64'(0));
            checkOutput($sformatf("post_rst%0d_stall", k), 64'(pipe_stall), 64'(0));
            checkOutput($sformatf("post_rst%0d_ready", k), 64'(mc_ready),   64'(1));
            checkOutput($sformatf("post_rst%0d_qpend", k), 64'(q_pending),  64'(0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
